// File: rtl/stack_tos_engine.sv
// Operand-stack engine: register-cached TOS over a single-port synchronous stack RAM.
// Optional call/return frame support is compiled in with `define STACK_FRAME_EN.
module stack_tos_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int FRAME_AW   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [DATA_WIDTH-1:0] op_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [DATA_WIDTH-1:0] tos_data,
    output logic [ADDR_WIDTH:0]   sp,
    output logic                  empty,
    output logic                  full,
    output logic                  err_pulse,
    output logic                  err_ovf,
    output logic                  err_udf,
    input  logic                  err_clr
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] SP_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] SP_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] SP_TWO  = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};

    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_DUP  = 3'b011;
    localparam logic [2:0] OP_SWAP = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;

    typedef enum logic [1:0] {IDLE, FILL, SWAP_WR} state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH:0]     sp_n, sp_m1, avail, fp;
    logic [ADDR_WIDTH-1:0]   idx1, idx2;
    logic [DATA_WIDTH-1:0]   tos_n, resp_data_n;
    logic                    resp_valid_n, set_ovf, set_udf;
    logic                    ram_we, ram_re;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [FRAME_AW:0]       frame_cnt;

    assign op_ready = (state == IDLE);
    assign empty    = (sp == '0);
    assign full     = (sp == SP_FULL);
    assign sp_m1    = sp - SP_ONE;
    assign avail    = sp - fp;
    assign idx1     = sp[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign idx2     = sp[ADDR_WIDTH-1:0] - ADDR_WIDTH'(2);

`ifdef STACK_FRAME_EN
    localparam logic [FRAME_AW:0] FRAME_FULL = {1'b1, {FRAME_AW{1'b0}}};
    localparam logic [FRAME_AW:0] FC_ONE     = {{FRAME_AW{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   frames [2**FRAME_AW];
    logic [ADDR_WIDTH:0]   fp_n;
    logic [ADDR_WIDTH-1:0] fp_idx;
    logic [FRAME_AW-1:0]   frame_top;
    logic                  frame_push, frame_pop;

    assign fp_idx    = fp[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign frame_top = frame_cnt[FRAME_AW-1:0] - FRAME_AW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fp        <= '0;
            frame_cnt <= '0;
        end else begin
            fp <= fp_n;
            if (frame_push)     frame_cnt <= frame_cnt + FC_ONE;
            else if (frame_pop) frame_cnt <= frame_cnt - FC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (frame_push) frames[frame_cnt[FRAME_AW-1:0]] <= fp;
    end
`else
    assign fp        = '0;
    assign frame_cnt = '0;
`endif

    // Single port: one address, and read/write enables are never raised together.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    always_comb begin
        state_n      = state;
        sp_n         = sp;
        tos_n        = tos_data;
        resp_data_n  = resp_data;
        resp_valid_n = 1'b0;
        set_ovf      = 1'b0;
        set_udf      = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = idx1;
        ram_wdata    = tos_data;
`ifdef STACK_FRAME_EN
        fp_n         = fp;
        frame_push   = 1'b0;
        frame_pop    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        OP_PUSH: begin
                            if (full) set_ovf = 1'b1;
                            else begin
                                ram_we = !empty;
                                tos_n  = op_data;
                                sp_n   = sp + SP_ONE;
                            end
                        end
                        OP_DUP: begin
                            if (empty)     set_udf = 1'b1;
                            else if (full) set_ovf = 1'b1;
                            else begin
                                ram_we = 1'b1;
                                sp_n   = sp + SP_ONE;
                            end
                        end
                        OP_POP: begin
                            if (avail == '0) set_udf = 1'b1;
                            else begin
                                resp_data_n  = tos_data;
                                resp_valid_n = 1'b1;
                                sp_n         = sp_m1;
                                if (sp_m1 != '0) begin
                                    ram_re   = 1'b1;
                                    ram_addr = idx2;
                                    state_n  = FILL;
                                end
                            end
                        end
                        OP_SWAP: begin
                            if (avail < SP_TWO) set_udf = 1'b1;
                            else begin
                                ram_re   = 1'b1;
                                ram_addr = idx2;
                                state_n  = SWAP_WR;
                            end
                        end
                        OP_CALL: begin
`ifdef STACK_FRAME_EN
                            if (frame_cnt == FRAME_FULL) set_ovf = 1'b1;
                            else begin
                                ram_we     = !empty;
                                frame_push = 1'b1;
                                fp_n       = sp;
                            end
`else
                            set_udf = 1'b1;
`endif
                        end
                        OP_RET: begin
                            if (frame_cnt == '0) set_udf = 1'b1;
                            else begin
`ifdef STACK_FRAME_EN
                                // TOS at CALL time was flushed to RAM[fp-1], so refill from there.
                                frame_pop = 1'b1;
                                sp_n      = fp;
                                fp_n      = frames[frame_top];
                                if (fp != '0) begin
                                    ram_re   = 1'b1;
                                    ram_addr = fp_idx;
                                    state_n  = FILL;
                                end
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            FILL: begin
                tos_n   = ram_rdata;
                state_n = IDLE;
            end
            SWAP_WR: begin
                ram_we   = 1'b1;
                ram_addr = idx2;
                tos_n    = ram_rdata;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sp         <= '0;
            tos_data   <= '0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            err_pulse  <= 1'b0;
            err_ovf    <= 1'b0;
            err_udf    <= 1'b0;
        end else begin
            state      <= state_n;
            sp         <= sp_n;
            tos_data   <= tos_n;
            resp_data  <= resp_data_n;
            resp_valid <= resp_valid_n;
            err_pulse  <= set_ovf | set_udf;
            err_ovf    <= set_ovf | (err_ovf & ~err_clr);
            err_udf    <= set_udf | (err_udf & ~err_clr);
        end
    end

endmodule
